// File: rtl/mem_seq_ctrl_pkg.sv
// Shared types and encodings for the memory sequencing controller.
package mem_seq_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        COMMIT = 3'd4,
        TRAP   = 3'd5
    } state_t;

    localparam logic [1:0] CAUSE_FETCH_TO     = 2'd0;
    localparam logic [1:0] CAUSE_DATA_TO      = 2'd1;
    localparam logic [1:0] CAUSE_LD_MISALIGN  = 2'd2;
    localparam logic [1:0] CAUSE_ST_MISALIGN  = 2'd3;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    // Access size vs. low address bits; other sizes are never flagged.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
        return ((size == SIZE_HALF) && off[0]) || ((size == SIZE_WORD) && (off != 2'b00));
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for stores and shift/extend for loads.
module lsu_align
    import mem_seq_ctrl_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [2:0]      funct3,
    input  logic [1:0]      addr,
    input  logic [XLEN-1:0] st_data,
    input  logic [XLEN-1:0] rdata,
    output logic [3:0]      be,
    output logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] ld_data
);

    logic [4:0]      shamt;
    logic [XLEN-1:0] shifted;

    always_comb begin
        shamt   = {addr, 3'b000};
        wdata   = st_data << shamt;
        shifted = rdata >> shamt;
        be      = 4'b1111;
        ld_data = shifted;
        case (funct3[1:0])
            SIZE_BYTE: begin
                be = 4'(4'b0001 << addr);
                if (funct3[2]) ld_data = XLEN'(shifted[7:0]);
                else           ld_data = XLEN'($signed(shifted[7:0]));
            end
            SIZE_HALF: begin
                be = 4'(4'b0011 << addr);
                if (funct3[2]) ld_data = XLEN'(shifted[15:0]);
                else           ld_data = XLEN'($signed(shifted[15:0]));
            end
            default: begin
                be = 4'b1111;
                if (funct3[2]) ld_data = XLEN'(shifted[31:0]);
                else           ld_data = XLEN'($signed(shifted[31:0]));
            end
        endcase
    end

endmodule

// File: rtl/mem_seq_ctrl.sv
// Multi-cycle instruction sequencer: fetch, execute, optional data access, commit.
module mem_seq_ctrl
    import mem_seq_ctrl_pkg::*;
#(
    parameter logic [31:0]  PC_START  = 32'h100d8,
    parameter int unsigned  XLEN      = 32,
    parameter int unsigned  TIMEOUT   = 1024,
    parameter int unsigned  CNT_W     = 32,
    parameter bit           CHK_ALIGN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enb,
    output logic             if_req,
    output logic [XLEN-1:0]  if_addr,
    input  logic             if_stall,
    input  logic [31:0]      if_rdata,
    output logic [31:0]      instr,
    output logic [XLEN-1:0]  pc,
    input  logic [XLEN-1:0]  pc_next,
    input  logic             is_load,
    input  logic             is_store,
    input  logic [2:0]       funct3,
    input  logic [XLEN-1:0]  mem_addr,
    input  logic [XLEN-1:0]  st_data,
    output logic             dm_rd,
    output logic             dm_wr,
    output logic [XLEN-1:0]  dm_addr,
    output logic [XLEN-1:0]  dm_wdata,
    output logic [3:0]       dm_be,
    input  logic             dm_stall,
    input  logic [XLEN-1:0]  dm_rdata,
    output logic [XLEN-1:0]  ld_data,
    output logic             commit,
    output logic             trap,
    output logic [1:0]       trap_cause,
    output logic [CNT_W-1:0] retired
);

    localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

    state_t            state, state_d;
    logic [TMO_W-1:0]  tmo_cnt, tmo_d;
    logic [2:0]        acc_f3, acc_f3_d;
    logic [1:0]        acc_off, acc_off_d;
    logic              acc_ld, acc_ld_d;
    logic [XLEN-1:0]   pc_d, dm_addr_d, dm_wdata_d, ld_data_d;
    logic [31:0]       instr_d;
    logic [3:0]        dm_be_d;
    logic [1:0]        trap_cause_d;
    logic [CNT_W-1:0]  retired_d;
    logic              if_req_d, dm_rd_d, dm_wr_d, commit_d, trap_d;
    logic              if_ack, dm_ack, mem_op, bad_align;
    logic [2:0]        lsu_f3;
    logic [1:0]        lsu_off;
    logic [3:0]        lsu_be;
    logic [XLEN-1:0]   lsu_wdata, lsu_ld;

    assign if_addr   = pc;
    assign if_ack    = if_req && !if_stall;
    assign dm_ack    = (dm_rd || dm_wr) && !dm_stall;
    assign mem_op    = is_load || is_store;
    assign bad_align = CHK_ALIGN && misaligned(funct3[1:0], mem_addr[1:0]);

    // Live decode steers store lanes in EXEC; the latched access drives load extension in MEM.
    assign lsu_f3  = (state == EXEC) ? funct3 : acc_f3;
    assign lsu_off = (state == EXEC) ? mem_addr[1:0] : acc_off;

    lsu_align #(.XLEN(XLEN)) u_lsu_align (
        .funct3  (lsu_f3),
        .addr    (lsu_off),
        .st_data (st_data),
        .rdata   (dm_rdata),
        .be      (lsu_be),
        .wdata   (lsu_wdata),
        .ld_data (lsu_ld)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            pc         <= XLEN'(PC_START);
            tmo_cnt    <= '0;
            acc_f3     <= '0;
            acc_off    <= '0;
            acc_ld     <= 1'b0;
            instr      <= '0;
            ld_data    <= '0;
            dm_addr    <= '0;
            dm_wdata   <= '0;
            dm_be      <= '0;
            if_req     <= 1'b0;
            dm_rd      <= 1'b0;
            dm_wr      <= 1'b0;
            commit     <= 1'b0;
            trap       <= 1'b0;
            trap_cause <= '0;
            retired    <= '0;
        end else begin
            state      <= state_d;
            pc         <= pc_d;
            tmo_cnt    <= tmo_d;
            acc_f3     <= acc_f3_d;
            acc_off    <= acc_off_d;
            acc_ld     <= acc_ld_d;
            instr      <= instr_d;
            ld_data    <= ld_data_d;
            dm_addr    <= dm_addr_d;
            dm_wdata   <= dm_wdata_d;
            dm_be      <= dm_be_d;
            if_req     <= if_req_d;
            dm_rd      <= dm_rd_d;
            dm_wr      <= dm_wr_d;
            commit     <= commit_d;
            trap       <= trap_d;
            trap_cause <= trap_cause_d;
            retired    <= retired_d;
        end
    end

    // Next state plus next values of every registered output.
    always_comb begin
        state_d      = state;
        pc_d         = pc;
        tmo_d        = '0;
        acc_f3_d     = acc_f3;
        acc_off_d    = acc_off;
        acc_ld_d     = acc_ld;
        instr_d      = instr;
        ld_data_d    = ld_data;
        dm_addr_d    = dm_addr;
        dm_wdata_d   = dm_wdata;
        dm_be_d      = dm_be;
        trap_cause_d = trap_cause;
        retired_d    = retired;

        case (state)
            IDLE: begin
                if (enb) state_d = FETCH;
            end
            FETCH: begin
                if (if_ack) begin
                    instr_d = if_rdata;
                    state_d = EXEC;
                end else if (tmo_cnt == TMO_W'(TIMEOUT - 1)) begin
                    state_d      = TRAP;
                    trap_cause_d = CAUSE_FETCH_TO;
                end else begin
                    tmo_d = tmo_cnt + TMO_W'(1);
                end
            end
            EXEC: begin
                if (mem_op && bad_align) begin
                    state_d      = TRAP;
                    trap_cause_d = is_load ? CAUSE_LD_MISALIGN : CAUSE_ST_MISALIGN;
                end else if (mem_op) begin
                    state_d    = MEM;
                    acc_ld_d   = is_load;
                    acc_f3_d   = funct3;
                    acc_off_d  = mem_addr[1:0];
                    dm_addr_d  = {mem_addr[XLEN-1:2], 2'b00};
                    dm_wdata_d = lsu_wdata;
                    dm_be_d    = lsu_be;
                end else begin
                    state_d = COMMIT;
                end
            end
            MEM: begin
                if (dm_ack) begin
                    if (acc_ld) ld_data_d = lsu_ld;
                    state_d = COMMIT;
                end else if (tmo_cnt == TMO_W'(TIMEOUT - 1)) begin
                    state_d      = TRAP;
                    trap_cause_d = CAUSE_DATA_TO;
                end else begin
                    tmo_d = tmo_cnt + TMO_W'(1);
                end
            end
            COMMIT: begin
                pc_d      = pc_next;
                retired_d = retired + CNT_W'(1);
                state_d   = enb ? FETCH : IDLE;
            end
            TRAP: begin
                state_d = TRAP;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if_req_d = (state_d == FETCH);
        dm_rd_d  = (state_d == MEM) && acc_ld_d;
        dm_wr_d  = (state_d == MEM) && !acc_ld_d;
        commit_d = (state_d == COMMIT);
        trap_d   = (state_d == TRAP);
    end

endmodule

// File: tb/tb_mem_seq_ctrl.sv
// Directed bench for mem_seq_ctrl: vector table plus multi-cycle corner sequences.
module tb_mem_seq_ctrl;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned CNT_W   = 3;
    localparam int unsigned TIMEOUT = 8;
    localparam logic [31:0] PC_RST  = 32'h000100d8;

    logic             clk, rst, enb;
    logic             if_req, if_stall;
    logic [XLEN-1:0]  if_addr;
    logic [31:0]      if_rdata, instr;
    logic [XLEN-1:0]  pc, pc_next, mem_addr, st_data;
    logic             is_load, is_store;
    logic [2:0]       funct3;
    logic             dm_rd, dm_wr, dm_stall;
    logic [XLEN-1:0]  dm_addr, dm_wdata, dm_rdata, ld_data;
    logic [3:0]       dm_be;
    logic             commit, trap;
    logic [1:0]       trap_cause;
    logic [CNT_W-1:0] retired;

    mem_seq_ctrl #(
        .PC_START (PC_RST),
        .XLEN     (XLEN),
        .TIMEOUT  (TIMEOUT),
        .CNT_W    (CNT_W),
        .CHK_ALIGN(1'b1)
    ) dut (
        .clk(clk), .rst(rst), .enb(enb),
        .if_req(if_req), .if_addr(if_addr), .if_stall(if_stall), .if_rdata(if_rdata),
        .instr(instr), .pc(pc), .pc_next(pc_next),
        .is_load(is_load), .is_store(is_store), .funct3(funct3),
        .mem_addr(mem_addr), .st_data(st_data),
        .dm_rd(dm_rd), .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_be(dm_be), .dm_stall(dm_stall), .dm_rdata(dm_rdata),
        .ld_data(ld_data), .commit(commit), .trap(trap),
        .trap_cause(trap_cause), .retired(retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        ld;
        logic        st;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] sdata;
        logic [31:0] rdata;
        logic [31:0] pcn;
        logic        exp_rd;
        logic        exp_wr;
        logic [3:0]  be;
        logic [31:0] daddr;
        logic [31:0] wdata;
        logic [31:0] ldv;
    } vec_t;

    vec_t        vecs [13];
    vec_t        hv;
    int          checks = 0;
    int          failures = 0;
    logic [31:0] m_pc, m_ld;
    logic [2:0]  m_ret;
    int          ifc, dmc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_dp(input vec_t v);
        is_load  = v.ld;
        is_store = v.st;
        funct3   = v.f3;
        mem_addr = v.addr;
        st_data  = v.sdata;
        dm_rdata = v.rdata;
        pc_next  = v.pcn;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        enb = 1'b0;
        step();
        rst = 1'b0;
        m_pc  = PC_RST;
        m_ret = '0;
        m_ld  = '0;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, " if_req"},  32'(if_req), 32'd0);
        chk({tag, " dm_rd"},   32'(dm_rd), 32'd0);
        chk({tag, " dm_wr"},   32'(dm_wr), 32'd0);
        chk({tag, " dm_be"},   32'(dm_be), 32'd0);
        chk({tag, " commit"},  32'(commit), 32'd0);
        chk({tag, " trap"},    32'(trap), 32'd0);
        chk({tag, " cause"},   32'(trap_cause), 32'd0);
        chk({tag, " pc"},      pc, PC_RST);
        chk({tag, " retired"}, 32'(retired), 32'd0);
        chk({tag, " instr"},   instr, 32'd0);
        chk({tag, " ld_data"}, ld_data, 32'd0);
    endtask

    // Entered with the FSM in FETCH; returns one cycle after the commit pulse.
    task automatic run_vec(input vec_t v, input logic [31:0] iw, input string tag);
        int          start = -1;
        int          lat = 0;
        bit          done = 1'b0;
        bit          saw_rd = 1'b0;
        bit          saw_wr = 1'b0;
        logic [3:0]  cbe = '0;
        logic [31:0] cadr = '0;
        logic [31:0] cwd = '0;
        set_dp(v);
        if_rdata = iw;
        for (int i = 0; i < 30; i++) begin
            if (if_req && start < 0) start = i;
            if (dm_rd || dm_wr) begin
                saw_rd = saw_rd | dm_rd;
                saw_wr = saw_wr | dm_wr;
                cbe = dm_be;
                cadr = dm_addr;
                cwd = dm_wdata;
            end
            if (commit) begin
                done = 1'b1;
                lat = i - start + 1;
                break;
            end
            step();
        end
        chk({tag, " commit_seen"}, 32'(done), 32'd1);
        if (done) begin
            chk({tag, " latency"}, 32'(lat), (v.ld || v.st) ? 32'd4 : 32'd3);
            chk({tag, " dm_rd"}, 32'(saw_rd), 32'(v.exp_rd));
            chk({tag, " dm_wr"}, 32'(saw_wr), 32'(v.exp_wr));
            if (v.ld || v.st) begin
                chk({tag, " dm_be"}, 32'(cbe), 32'(v.be));
                chk({tag, " dm_addr"}, cadr, v.daddr);
            end
            if (v.exp_wr) chk({tag, " dm_wdata"}, cwd, v.wdata);
            chk({tag, " instr"}, instr, iw);
            step();
            m_pc  = v.pcn;
            m_ret = m_ret + 3'd1;
            if (v.ld) m_ld = v.ldv;
            chk({tag, " pc"}, pc, m_pc);
            chk({tag, " retired"}, 32'(retired), 32'(m_ret));
            chk({tag, " ld_data"}, ld_data, m_ld);
            chk({tag, " commit_1cyc"}, 32'(commit), 32'd0);
        end
    endtask

    task automatic wait_commit(input string tag);
        bit done = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (commit) begin
                done = 1'b1;
                break;
            end
            step();
        end
        chk({tag, " commit_seen"}, 32'(done), 32'd1);
        step();
    endtask

    task automatic wait_trap(input string tag, output int if_cyc, output int dm_cyc);
        bit seen = 1'b0;
        if_cyc = 0;
        dm_cyc = 0;
        for (int i = 0; i < 40; i++) begin
            if (trap) begin
                seen = 1'b1;
                break;
            end
            if (if_req) if_cyc++;
            if (dm_rd || dm_wr) dm_cyc++;
            step();
        end
        chk({tag, " trap_seen"}, 32'(seen), 32'd1);
    endtask

    initial begin
        rst = 1'b1; enb = 1'b0; if_stall = 1'b0; dm_stall = 1'b0; if_rdata = '0;
        pc_next = '0; is_load = 1'b0; is_store = 1'b0; funct3 = '0;
        mem_addr = '0; st_data = '0; dm_rdata = '0;
        m_pc = PC_RST; m_ret = '0; m_ld = '0;

        //            ld    st    f3      addr          sdata         rdata         pcn           rd    wr    be       daddr         wdata         ldv
        vecs[0]  = '{1'b0,1'b0,3'b000,32'h00000000,32'h00000000,32'h00000000,32'h000100dc,1'b0,1'b0,4'b0000,32'h00000000,32'h00000000,32'h00000000};
        vecs[1]  = '{1'b1,1'b0,3'b000,32'h00001003,32'h00000000,32'h80112233,32'h000100e0,1'b1,1'b0,4'b1000,32'h00001000,32'h00000000,32'hFFFFFF80};
        vecs[2]  = '{1'b1,1'b0,3'b100,32'h00001003,32'h00000000,32'h80112233,32'h000100e4,1'b1,1'b0,4'b1000,32'h00001000,32'h00000000,32'h00000080};
        vecs[3]  = '{1'b0,1'b1,3'b001,32'h00002002,32'h0000ABCD,32'h00000000,32'h000100e8,1'b0,1'b1,4'b1100,32'h00002000,32'hABCD0000,32'h00000000};
        vecs[4]  = '{1'b1,1'b0,3'b010,32'h00003000,32'h00000000,32'hDEADBEEF,32'h000100ec,1'b1,1'b0,4'b1111,32'h00003000,32'h00000000,32'hDEADBEEF};
        vecs[5]  = '{1'b1,1'b0,3'b001,32'h00004002,32'h00000000,32'h87651234,32'h000100f0,1'b1,1'b0,4'b1100,32'h00004000,32'h00000000,32'hFFFF8765};
        vecs[6]  = '{1'b1,1'b0,3'b101,32'h00004002,32'h00000000,32'h87651234,32'h000100f4,1'b1,1'b0,4'b1100,32'h00004000,32'h00000000,32'h00008765};
        vecs[7]  = '{1'b0,1'b1,3'b000,32'h00005001,32'h000000A5,32'h00000000,32'h000100f8,1'b0,1'b1,4'b0010,32'h00005000,32'h0000A500,32'h00000000};
        vecs[8]  = '{1'b0,1'b1,3'b010,32'h00006004,32'h12345678,32'h00000000,32'h000100fc,1'b0,1'b1,4'b1111,32'h00006004,32'h12345678,32'h00000000};
        vecs[9]  = '{1'b1,1'b1,3'b000,32'h00007000,32'hFFFFFFFF,32'h0000007F,32'h00010100,1'b1,1'b0,4'b0001,32'h00007000,32'h00000000,32'h0000007F};
        vecs[10] = '{1'b0,1'b0,3'b010,32'h00007001,32'h00000000,32'h00000000,32'h00020000,1'b0,1'b0,4'b0000,32'h00000000,32'h00000000,32'h00000000};
        vecs[11] = '{1'b1,1'b0,3'b000,32'h00001002,32'h00000000,32'h80112233,32'h00020004,1'b1,1'b0,4'b0100,32'h00001000,32'h00000000,32'h00000011};
        vecs[12] = '{1'b1,1'b0,3'b101,32'h00000000,32'h00000000,32'h0000FFFF,32'h00020008,1'b1,1'b0,4'b0011,32'h00000000,32'h00000000,32'h0000FFFF};

        step(); step();
        check_reset("por");
        rst = 1'b0; enb = 1'b1;
        step();
        chk("first if_req", 32'(if_req), 32'd1);
        chk("first if_addr", if_addr, 32'h000100d8);
        run_vec(vecs[0], 32'h00000013, "v0");

        // Fetch held off by L1I for five cycles.
        hv = vecs[0];
        hv.pcn = 32'h00000300;
        set_dp(hv);
        if_stall = 1'b1;
        if_rdata = 32'hABCD0013;
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("ifstall req c%0d", k), 32'(if_req), 32'd1);
            chk($sformatf("ifstall addr c%0d", k), if_addr, m_pc);
            step();
        end
        if_stall = 1'b0;
        chk("ifstall req c5", 32'(if_req), 32'd1);
        step();
        chk("ifstall instr", instr, 32'hABCD0013);
        chk("ifstall req drop", 32'(if_req), 32'd0);
        wait_commit("ifstall");
        m_pc = 32'h00000300;
        m_ret = m_ret + 3'd1;
        chk("ifstall pc", pc, m_pc);
        chk("ifstall retired", 32'(retired), 32'(m_ret));

        for (int i = 1; i < 13; i++) run_vec(vecs[i], 32'h10000000 + 32'(i), $sformatf("v%0d", i));

        // enb dropped while a load is stalled in MEM.
        hv = vecs[4];
        hv.rdata = 32'hCAFEF00D;
        hv.pcn = 32'h00000400;
        set_dp(hv);
        dm_stall = 1'b1;
        for (int i = 0; i < 10 && !dm_rd; i++) step();
        chk("enbdrop dm_rd", 32'(dm_rd), 32'd1);
        enb = 1'b0;
        step(); step();
        chk("enbdrop rd_hold", 32'(dm_rd), 32'd1);
        chk("enbdrop addr_hold", dm_addr, 32'h00003000);
        dm_stall = 1'b0;
        wait_commit("enbdrop");
        m_pc = 32'h00000400;
        m_ret = m_ret + 3'd1;
        chk("enbdrop pc", pc, m_pc);
        chk("enbdrop ld_data", ld_data, 32'hCAFEF00D);
        chk("enbdrop retired", 32'(retired), 32'(m_ret));
        step();
        chk("enbdrop idle", 32'(if_req), 32'd0);
        enb = 1'b1;
        step();
        chk("enbdrop restart", 32'(if_req), 32'd1);

        // Reset arriving during an outstanding store.
        set_dp(vecs[8]);
        dm_stall = 1'b1;
        for (int i = 0; i < 10 && !dm_wr; i++) step();
        chk("rstmem dm_wr", 32'(dm_wr), 32'd1);
        do_reset();
        dm_stall = 1'b0;
        check_reset("rstmem");
        step();
        chk("rstmem stay_idle", 32'(if_req), 32'd0);

        // Misaligned word load.
        enb = 1'b1;
        step();
        hv = vecs[4];
        hv.addr = 32'h00002001;
        set_dp(hv);
        wait_trap("lmis", ifc, dmc);
        chk("lmis cause", 32'(trap_cause), 32'd2);
        chk("lmis no_dm", 32'(dmc), 32'd0);
        step(); step();
        chk("lmis absorb", 32'(trap), 32'd1);
        chk("lmis no_req", 32'(if_req | dm_rd | dm_wr), 32'd0);
        chk("lmis pc", pc, m_pc);
        chk("lmis retired", 32'(retired), 32'd0);

        // Misaligned half store.
        do_reset();
        chk("smis cleared", 32'(trap), 32'd0);
        enb = 1'b1;
        step();
        hv = vecs[3];
        hv.addr = 32'h00002003;
        set_dp(hv);
        wait_trap("smis", ifc, dmc);
        chk("smis cause", 32'(trap_cause), 32'd3);
        chk("smis no_dm", 32'(dmc), 32'd0);

        // Data-side timeout.
        do_reset();
        enb = 1'b1;
        step();
        set_dp(vecs[4]);
        dm_stall = 1'b1;
        wait_trap("dto", ifc, dmc);
        chk("dto dm_cycles", 32'(dmc), 32'(TIMEOUT));
        chk("dto cause", 32'(trap_cause), 32'd1);
        chk("dto pc", pc, m_pc);
        step();
        chk("dto no_req", 32'(if_req | dm_rd | dm_wr), 32'd0);
        dm_stall = 1'b0;

        // Fetch-side timeout.
        do_reset();
        enb = 1'b1;
        if_stall = 1'b1;
        step();
        wait_trap("fto", ifc, dmc);
        chk("fto if_cycles", 32'(ifc), 32'(TIMEOUT));
        chk("fto cause", 32'(trap_cause), 32'd0);
        if_stall = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
